// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment encoder and scan decoder blocks:
// segment codes (bit 0 = a .. bit 6 = g, active-high), result kind encoding,
// decoder FSM states and the default stability window.
// No ports (package).
// ---------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [0:6] SEG_0 = 7'b1111110;
    localparam logic [0:6] SEG_1 = 7'b0110000;
    localparam logic [0:6] SEG_2 = 7'b1101101;
    localparam logic [0:6] SEG_3 = 7'b1111001;
    localparam logic [0:6] SEG_E = 7'b1001111;

    localparam int STABLE_CYCLES_DEFAULT = 4;

    typedef enum logic [1:0] {
        KIND_NUM = 2'b00,
        KIND_E   = 2'b01,
        KIND_INV = 2'b10
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_COUNT = 2'b01,
        ST_HOLD  = 2'b10
    } state_e;

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_decoder_if
// Bundles the scanned display inputs and the captured-result outputs.
//   seg_in     : segment code, [0:6] = a..g
//   dig_en     : one-hot digit enable
//   out_ready  : consumer ready
//   ovf_clr    : clears the sticky overflow flag
//   out_valid  : a captured result is held
//   out_digit  : digit index of the held result
//   out_value  : decoded value
//   out_kind   : result kind (numeric / E / invalid)
//   frame_done : one-cycle pulse when every digit has been captured
//   ovf        : sticky overflow (capture dropped)
// Modports: slave = decoder side, master = driver/consumer side.
// ---------------------------------------------------------------------------
interface seg7_scan_decoder_if
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);
    localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [0:6]            seg_in;
    logic [NUM_DIGITS-1:0] dig_en;
    logic                  out_ready;
    logic                  ovf_clr;
    logic                  out_valid;
    logic [DIG_W-1:0]      out_digit;
    logic [2:0]            out_value;
    kind_e                 out_kind;
    logic                  frame_done;
    logic                  ovf;

    modport master (
        output seg_in, dig_en, out_ready, ovf_clr,
        input  out_valid, out_digit, out_value, out_kind, frame_done, ovf
    );

    modport slave (
        input  seg_in, dig_en, out_ready, ovf_clr,
        output out_valid, out_digit, out_value, out_kind, frame_done, ovf
    );

endinterface

// File: rtl/seg7_code_lookup.sv
// ---------------------------------------------------------------------------
// seg7_code_lookup
// Combinational segment-code to value/kind decode.
//   seg   : segment code, [0:6] = a..g
//   value : decoded value (0 for unrecognised codes)
//   kind  : KIND_NUM for 0..3, KIND_E for the E code, KIND_INV otherwise
// ---------------------------------------------------------------------------
module seg7_code_lookup
    import seg7_pkg::*;
(
    input  logic [0:6] seg,
    output logic [2:0] value,
    output kind_e      kind
);

    always_comb begin
        value = 3'd0;
        kind  = KIND_INV;
        case (seg)
            SEG_0: begin value = 3'd0; kind = KIND_NUM; end
            SEG_1: begin value = 3'd1; kind = KIND_NUM; end
            SEG_2: begin value = 3'd2; kind = KIND_NUM; end
            SEG_3: begin value = 3'd3; kind = KIND_NUM; end
            SEG_E: begin value = 3'd4; kind = KIND_E;   end
            default: ;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg7_scan_decoder
// Samples a multiplexed seven-segment display, waits for a digit to be stable
// for STABLE_CYCLES samples, decodes it and presents one result at a time on
// a valid/ready output register. Tracks which digits were captured and
// pulses frame_done when all have been seen; flags dropped captures in ovf.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : seg7_scan_decoder_if.slave (scan inputs, result outputs)
// ---------------------------------------------------------------------------
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
    parameter int NUM_DIGITS    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg7_scan_decoder_if.slave   bus
);

    localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [NUM_DIGITS-1:0] MASK_FULL = '1;

    function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < NUM_DIGITS; i++) n += int'(v[i]);
        return (n == 1);
    endfunction

    function automatic logic [DIG_W-1:0] onehot_idx(input logic [NUM_DIGITS-1:0] v);
        logic [DIG_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) if (v[i]) idx = DIG_W'(i);
        return idx;
    endfunction

    logic [0:6]            seg_p0, seg_p1;
    logic [NUM_DIGITS-1:0] dig_p0, dig_p1;
    state_e                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  capture;
    logic                  onehot_p0, same_p0, stable_p0;
    logic [8:0]            cnt_inc;
    logic [2:0]            lk_value;
    kind_e                 lk_kind;
    logic [DIG_W-1:0]      cap_digit;
    logic                  out_valid_q, frame_done_q, ovf_q;
    logic [DIG_W-1:0]      out_digit_q;
    logic [2:0]            out_value_q;
    kind_e                 out_kind_q;
    logic [NUM_DIGITS-1:0] mask_q, mask_set;
    logic                  accept, drop;

    // Stage p0: registered sample; p1: previous sample for the stability compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_p0 <= '0;
            seg_p1 <= '0;
            dig_p0 <= '0;
            dig_p1 <= '0;
        end else begin
            seg_p0 <= bus.seg_in;
            seg_p1 <= seg_p0;
            dig_p0 <= bus.dig_en;
            dig_p1 <= dig_p0;
        end
    end

    assign onehot_p0 = is_onehot(dig_p0);
    assign same_p0   = (seg_p0 == seg_p1) && (dig_p0 == dig_p1);
    assign stable_p0 = same_p0 && onehot_p0;
    // cnt_q counts identical samples up to p1, so the sample in p0 makes it +1
    assign cnt_inc   = {1'b0, cnt_q} + 9'd1;

    seg7_code_lookup u_lookup (
        .seg   (seg_p0),
        .value (lk_value),
        .kind  (lk_kind)
    );

    assign cap_digit = onehot_idx(dig_p0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        if (!onehot_p0) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_COUNT;
                    cnt_d   = 8'd1;
                end
                ST_COUNT: begin
                    if (!stable_p0) begin
                        cnt_d = 8'd1;
                    end else if (cnt_inc >= 9'(STABLE_CYCLES)) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                        capture = 1'b1;
                    end else begin
                        cnt_d = cnt_inc[7:0];
                    end
                end
                ST_HOLD: begin
                    if (!same_p0) begin
                        state_d = ST_COUNT;
                        cnt_d   = 8'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // A capture may load when the register is empty or is being drained this cycle
    assign accept   = capture && (!out_valid_q || bus.out_ready);
    assign drop     = capture && out_valid_q && !bus.out_ready;
    assign mask_set = mask_q | (NUM_DIGITS'(1) << cap_digit);

    // Stage p1: output register, digit mask and overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_digit_q  <= '0;
            out_value_q  <= '0;
            out_kind_q   <= KIND_NUM;
            frame_done_q <= 1'b0;
            mask_q       <= '0;
            ovf_q        <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (accept) begin
                out_valid_q <= 1'b1;
                out_digit_q <= cap_digit;
                out_value_q <= lk_value;
                out_kind_q  <= lk_kind;
                if (mask_set == MASK_FULL) begin
                    frame_done_q <= 1'b1;
                    mask_q       <= '0;
                end else begin
                    mask_q <= mask_set;
                end
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            // A new drop outranks a clear in the same cycle
            if (drop) ovf_q <= 1'b1;
            else if (bus.ovf_clr) ovf_q <= 1'b0;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_digit  = out_digit_q;
    assign bus.out_value  = out_value_q;
    assign bus.out_kind   = out_kind_q;
    assign bus.frame_done = frame_done_q;
    assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_decoder
// Self-checking bench for seg7_scan_decoder: table-driven scan vectors with a
// scoreboard of expected results, plus hand-written overflow and reset
// sequences.
// ---------------------------------------------------------------------------
module tb_seg7_scan_decoder;
    import seg7_pkg::*;

    localparam int NUM_DIGITS = 4;
    localparam int STABLE     = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    seg7_scan_decoder_if #(.NUM_DIGITS(NUM_DIGITS)) bus ();

    seg7_scan_decoder #(
        .STABLE_CYCLES (STABLE),
        .NUM_DIGITS    (NUM_DIGITS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int digit;
        int value;
        int kind;
        bit frame;
    } exp_t;

    typedef struct {
        logic [3:0] dig;
        logic [0:6] seg;
        int         hold;
        bit         cap;
        int         exp_digit;
        int         exp_value;
        int         exp_kind;
    } vec_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    exp_t       exp_q[$];
    logic [3:0] model_mask = 4'b0000;
    vec_t       tab[11];

    task automatic chk(input string name, input logic [31:0] act, input int req);
        n_checks++;
        if (act !== 32'(req)) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push_exp(input int d, input int v, input int k);
        exp_t e;
        model_mask = model_mask | (4'b0001 << d);
        e.digit = d;
        e.value = v;
        e.kind  = k;
        e.frame = (model_mask == 4'b1111);
        if (e.frame) model_mask = 4'b0000;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] d, input logic [0:6] s);
        bus.dig_en = d;
        bus.seg_in = s;
    endtask

    // Scoreboard: every completed transfer must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_capture: got digit %0d value %0d kind %0d, required no capture",
                             bus.out_digit, bus.out_value, bus.out_kind);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_digit", 32'(bus.out_digit), e.digit);
                    chk("sb_value", 32'(bus.out_value), e.value);
                    chk("sb_kind", 32'(bus.out_kind), e.kind);
                    chk("sb_frame_done", 32'(bus.frame_done), int'(e.frame));
                end
            end else if (!bus.out_valid) begin
                chk("frame_done_idle", 32'(bus.frame_done), 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tab[0]  = '{4'b0001, SEG_2,     8,  1'b1, 0, 2, 0};
        tab[1]  = '{4'b0001, SEG_0,     6,  1'b1, 0, 0, 0};
        tab[2]  = '{4'b0010, SEG_1,     6,  1'b1, 1, 1, 0};
        tab[3]  = '{4'b0100, SEG_3,     6,  1'b1, 2, 3, 0};
        tab[4]  = '{4'b1000, SEG_E,     6,  1'b1, 3, 4, 1};
        tab[5]  = '{4'b0001, SEG_1,     3,  1'b0, 0, 0, 0};
        tab[6]  = '{4'b0001, SEG_0,     3,  1'b0, 0, 0, 0};
        tab[7]  = '{4'b0001, SEG_1,     3,  1'b0, 0, 0, 0};
        tab[8]  = '{4'b0001, SEG_0,     3,  1'b0, 0, 0, 0};
        tab[9]  = '{4'b0011, SEG_0,     10, 1'b0, 0, 0, 0};
        tab[10] = '{4'b0010, 7'b0000001, 6, 1'b1, 1, 0, 2};

        bus.seg_in    = '0;
        bus.dig_en    = '0;
        bus.out_ready = 1'b1;
        bus.ovf_clr   = 1'b0;
        rst_n         = 1'b0;
        repeat (3) step();

        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_digit", 32'(bus.out_digit), 0);
        chk("rst_out_value", 32'(bus.out_value), 0);
        chk("rst_out_kind", 32'(bus.out_kind), 0);
        chk("rst_frame_done", 32'(bus.frame_done), 0);
        chk("rst_ovf", 32'(bus.ovf), 0);

        #2 rst_n = 1'b1;
        step();

        for (int i = 0; i < 11; i++) begin
            drive(tab[i].dig, tab[i].seg);
            if (tab[i].cap) push_exp(tab[i].exp_digit, tab[i].exp_value, tab[i].exp_kind);
            repeat (tab[i].hold) step();
            chk($sformatf("vec%0d_pending", i), 32'(exp_q.size()), 0);
        end
        chk("ovf_after_table", 32'(bus.ovf), 0);

        // Held result and overflow with the consumer stalled
        bus.out_ready = 1'b0;
        drive(4'b0100, SEG_2);
        push_exp(2, 2, 0);
        repeat (6) step();
        chk("stall_valid", 32'(bus.out_valid), 1);
        drive(4'b1000, SEG_3);
        repeat (6) step();
        chk("drop_ovf", 32'(bus.ovf), 1);
        chk("drop_hold_valid", 32'(bus.out_valid), 1);
        chk("drop_hold_digit", 32'(bus.out_digit), 2);
        chk("drop_hold_value", 32'(bus.out_value), 2);
        chk("drop_hold_kind", 32'(bus.out_kind), 0);
        bus.ovf_clr = 1'b1;
        step();
        bus.ovf_clr = 1'b0;
        chk("ovf_clr", 32'(bus.ovf), 0);
        drive(4'b0001, SEG_0);
        repeat (4) step();
        bus.ovf_clr = 1'b1;
        step();
        bus.ovf_clr = 1'b0;
        chk("ovf_clr_vs_drop", 32'(bus.ovf), 1);
        chk("third_drop_digit", 32'(bus.out_digit), 2);
        bus.out_ready = 1'b1;
        step();
        step();
        chk("stall_drained", 32'(exp_q.size()), 0);
        chk("stall_valid_low", 32'(bus.out_valid), 0);

        // Reset in the middle of a stability count
        drive(4'b0001, SEG_1);
        step();
        step();
        rst_n = 1'b0;
        #2;
        chk("async_rst_valid", 32'(bus.out_valid), 0);
        chk("async_rst_digit", 32'(bus.out_digit), 0);
        chk("async_rst_value", 32'(bus.out_value), 0);
        chk("async_rst_kind", 32'(bus.out_kind), 0);
        chk("async_rst_frame", 32'(bus.frame_done), 0);
        chk("async_rst_ovf", 32'(bus.ovf), 0);
        model_mask = 4'b0000;
        #4 rst_n = 1'b1;
        push_exp(0, 1, 0);
        repeat (4) step();
        chk("post_rst_no_early_capture", 32'(bus.out_valid), 0);
        step();
        chk("post_rst_capture", 32'(bus.out_valid), 1);
        step();
        chk("post_rst_drained", 32'(exp_q.size()), 0);

        drive(4'b0000, SEG_0);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, is the number of consecutive identical samples required before a digit is captured (legal range 2..255).
REQ-002 Parameter NUM_DIGITS, default 4, is the number of multiplexed digit positions (legal range 2..8).
REQ-003 Port clk, input, 1, is the single rising-edge clock.
REQ-004 Port rst_n, input, 1, is the reset: asynchronous and active-low.
REQ-005 Port seg_in, input, 7, declared [0:6], is the segment code with bit 0 = a through bit 6 = g, active-high.
REQ-006 Port dig_en, input, NUM_DIGITS, is the active-high digit enable, legal only when one-hot.
REQ-007 Port out_ready, input, 1, is the consumer ready signal.
REQ-008 Port ovf_clr, input, 1, clears the overflow flag.
REQ-009 Port out_valid, output, 1, indicates a captured result is held.
REQ-010 Port out_digit, output, clog2(NUM_DIGITS), is the digit index of the held result.
REQ-011 Port out_value, output, 3, is the decoded binary value.
REQ-012 Port out_kind, output, 2, encodes the result kind: 00 = numeric, 01 = E code, 10 = invalid.
REQ-013 Port frame_done, output, 1, is a one-cycle pulse marking a complete frame.
REQ-014 Port ovf, output, 1, is the sticky overflow flag.

Function
REQ-015 Decode table SHALL be: 1111110->0, 0110000->1, 1101101->2, 1111001->3 (kind 00); 1001111->value 4, kind 01; any other code->value 0, kind 10.
REQ-016 seg_in and dig_en SHALL be registered each cycle; a sample counts as "stable" when both equal the previous registered sample and dig_en is one-hot.
REQ-017 FSM states SHALL be IDLE, COUNT and HOLD.
REQ-018 IDLE->COUNT on a one-hot dig_en; COUNT->HOLD when the stable count reaches STABLE_CYCLES; HOLD->COUNT when a one-hot dig_en or seg_in changes; any state->IDLE on a zero or multi-hot dig_en.
REQ-019 A non-stable sample in COUNT SHALL restart the count at 1 (the new sample is the first sample).
REQ-020 Exactly one capture SHALL be issued per COUNT->HOLD transition; HOLD SHALL never re-capture an unchanged input.
REQ-021 Latency: out_valid SHALL rise on the clock edge after the STABLE_CYCLES-th consecutive identical sample is registered.
REQ-022 The output register SHALL be one deep; out_valid and all out_* fields SHALL hold constant while out_valid=1 and out_ready=0.
REQ-023 The transfer completes on a cycle with out_valid=1 and out_ready=1; a capture in that same cycle SHALL load the register so that out_valid stays 1 with the new fields.
REQ-024 A capture while out_valid=1 and out_ready=0 SHALL be dropped and SHALL set ovf.
REQ-025 ovf_clr SHALL clear ovf; a simultaneous new overflow SHALL win, leaving ovf at 1.
REQ-026 A digit mask SHALL set the bit for out_digit on each accepted capture; dropped captures SHALL not set it.
REQ-027 When an accepted capture completes the mask, frame_done SHALL pulse for one cycle coincident with that out_valid load, and the mask SHALL clear in the same cycle.
REQ-028 An invalid-kind capture SHALL count toward the mask like any other capture.

Reset
REQ-029 On rst_n low, state SHALL be IDLE, the counter, mask and sample registers SHALL be 0, and out_valid, out_digit, out_value, out_kind, frame_done and ovf SHALL be 0, asynchronously.
REQ-030 Reset deassertion mid-digit SHALL restart stability counting from IDLE; no partial count SHALL survive reset.

Structure
REQ-031 Shared package seg7_pkg SHALL hold the SEG_0..SEG_3 and SEG_E code constants, the kind enum (KIND_NUM, KIND_E, KIND_INV) and the STABLE_CYCLES default; the existing encoder and this block SHALL both use it.
REQ-032 A combinational sub-module seg7_code_lookup SHALL implement REQ-015; the FSM, counter, output register, mask and ovf logic reside in seg7_scan_decoder.

Verification
REQ-033 dig_en=0001 and seg_in=1101101 held for 4 cycles, out_ready=1 -> one out_valid with digit 0, value 2, kind 00; no second capture while held.
REQ-034 Scan digits 0..3 with codes for 0,1,3,E, each held 6 cycles, out_ready=1 -> four captures, then frame_done pulses with the digit-3 capture (value 4, kind 01), and the mask clears.
REQ-035 seg_in toggling between 0110000 and 1111110 every 3 cycles -> no capture ever; dig_en=0011 for 10 cycles -> no capture.
REQ-036 out_ready=0 with two successive captures -> first result held unchanged, ovf=1; pulsing ovf_clr -> ovf=0; ovf_clr coinciding with a third drop -> ovf stays 1.
REQ-037 seg_in=0000001 stable -> value 0, kind 10; rst_n pulsed low at count 2 -> all outputs 0 immediately, and a capture needs 4 fresh stable cycles after release.
